jump_ctrl: RTL
==============

Name: jump_ctrl

Overview:
- Game-logic stage directly upstream of the character sprite/movement block.
- Turns debounced keyboard levels into one-cycle jump_left / jump_right / jump_fail commands.
- Blocks further commands until the character block pulses landed.
- Holds the next-platform side (pseudo-random LFSR), a 4-digit BCD score and the game_over flag for the platform-drawing and score-display stages.

Parameters:
- LFSR_SEED, 16'hACE1, initial LFSR value; 0 is replaced by 16'h0001.
- SCORE_DIGITS, 4, number of BCD digits in score (fixed 4 for this revision).
- TIMEOUT_CYCLES, 32'd120_000_000, idle cycles before a forced fail (3 s at 40 MHz); used only with the optional feature.

Ports:
- clk  in  1  40 MHz system clock
- rst  in  1  synchronous, active-high reset
- module_en  in  1  0 = hold block in reset state (same effect as rst)
- key_left  in  1  debounced level, 1 = left key held
- key_right  in  1  debounced level, 1 = right key held
- landed  in  1  one-cycle pulse from character block: jump/fall finished
- jump_left  out  1  one-cycle pulse: correct jump to the left
- jump_right  out  1  one-cycle pulse: correct jump to the right
- jump_fail  out  1  one-cycle pulse: wrong side chosen, character falls
- next_side  out  1  side of next platform, 0 = left, 1 = right
- score  out  16  4 BCD digits, score[3:0] = units
- game_over  out  1  level, set after fail landing, cleared only by rst/module_en=0

Behaviour:
- Reset (rst=1 or module_en=0, sync):
  - state=S_WAIT_KEY; all pulses 0; score=0; game_over=0.
  - lfsr=LFSR_SEED (0 → 1); next_side=LFSR_SEED[0]; key edge registers=0.
- Edge detect: rise_l = key_left & ~key_left_q, rise_r likewise; key_*_q updates every cycle in every state.
- S_WAIT_KEY:
  - exactly one of rise_l/rise_r → issue command next cycle (outputs registered, latency 1 clk from rising key sample), go to S_WAIT_LAND.
  - rise_l with next_side=0 → jump_left; rise_r with next_side=1 → jump_right; otherwise jump_fail.
  - Remember fail flag.
  - rise_l & rise_r in the same cycle → ignored, stay.
  - Held key (no new edge) → no action.
- S_WAIT_LAND:
  - All key edges ignored (not queued).
  - landed=1 and fail flag=0:
    - score += 1 in BCD, saturating at 9999.
    - lfsr advances one step (x^16+x^15+x^13+x^4+1, Fibonacci, shift left, feedback into bit 0).
    - next_side = new lfsr[0].
    - → S_WAIT_KEY.
  - landed=1 and fail flag=1: game_over=1 → S_GAME_OVER; score and next_side frozen.
- S_GAME_OVER: absorbing; all inputs ignored; pulses stay 0.
- landed outside S_WAIT_LAND: ignored.
- Exactly one command pulse per jump; never two pulses in the same cycle.
- Reset mid-jump: state returns to S_WAIT_KEY; a later stray landed is ignored.

Optional Feature:
- Macro: JUMP_CTRL_TIMEOUT_EN.
- Defined:
  - 32-bit idle counter clears on entry to S_WAIT_KEY and counts each cycle there.
  - Reaching TIMEOUT_CYCLES-1 issues jump_fail (fail flag set) → S_WAIT_LAND.
  - A valid key edge on the same cycle takes priority over the timeout.
- Not defined: no counter; block waits for a key indefinitely.

Decomposition:
- Shared package/header (macros.vh):
  - state encodings S_WAIT_KEY=2'b00, S_WAIT_LAND=2'b01, S_GAME_OVER=2'b10.
  - SIDE_LEFT=0, SIDE_RIGHT=1.
  - LFSR tap constant.
  - score width 16.
- One sub-module: bcd_counter (4 digits, inc pulse, synchronous clear, saturate at 9999).
- LFSR stays inline.

Test Plan:
- Seed 16'hACE1 (next_side=1), rise key_right → jump_right=1 exactly 1 cycle, one clk after edge. landed → score=16'h0001, next_side = lfsr-step(ACE1)[0].
- next_side=1, rise key_left → jump_fail pulse. landed → game_over=1, score unchanged. Later keys/landed → no pulses.
- Both keys rise same cycle → no pulse. Key held 1000 cycles after jump, then landed → no new command until release and re-press.
- Key edges during S_WAIT_LAND → ignored. Only one pulse per landed cycle.
- Preload 9999 via 9999 correct jumps (forced-side bench) → one more landed → score stays 16'h9999.
- JUMP_CTRL_TIMEOUT_EN, TIMEOUT_CYCLES=100 → no keys → jump_fail at cycle 100 after entering S_WAIT_KEY. Without macro → no pulse after 10000 cycles.

Source files
------------

// File: rtl/jump_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jump_ctrl_pkg
//  Description : Shared definitions for the jump controller: FSM state
//                encoding, platform side constants, LFSR taps and a
//                single-step LFSR helper.
//  Contents    : state_t        - FSM states (2-bit)
//                SIDE_LEFT/RIGHT - platform side encoding
//                LFSR_TAPS      - x^16+x^15+x^13+x^4+1 tap mask
//                SCORE_W        - score bus width (4 BCD digits)
//                lfsr_step()    - one Fibonacci step, shift left
//  Revision    : 1.0 - initial release
// ============================================================================
package jump_ctrl_pkg;

   typedef enum logic [1:0] {
      S_WAIT_KEY  = 2'b00,
      S_WAIT_LAND = 2'b01,
      S_GAME_OVER = 2'b10
   } state_t;

   localparam logic SIDE_LEFT  = 1'b0;
   localparam logic SIDE_RIGHT = 1'b1;

   // Bits 15, 14, 12 and 3 feed the XOR (polynomial exponents minus one).
   localparam logic [15:0] LFSR_TAPS = 16'hD008;

   localparam int SCORE_W = 16;

   // Fibonacci LFSR: shift left, parity of the tapped bits enters bit 0.
   function automatic logic [15:0] lfsr_step(input logic [15:0] i_val);
      return {i_val[14:0], ^(i_val & LFSR_TAPS)};
   endfunction

endpackage
`default_nettype wire

// File: rtl/jump_ctrl_bcd_counter.sv
`default_nettype none
// ============================================================================
//  Module      : jump_ctrl_bcd_counter
//  Description : Multi-digit BCD up-counter with increment pulse,
//                synchronous clear, saturating at all nines.
//  Ports       : clk      - clock
//                rst      - synchronous active-high reset
//                i_clr    - synchronous clear (same effect as rst)
//                i_inc    - one-cycle increment request
//                o_count  - BCD value, o_count[3:0] = units
//  Revision    : 1.0 - initial release
// ============================================================================
module jump_ctrl_bcd_counter #(
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_clr,
   input  logic                  i_inc,
   output logic [4*DIGITS-1:0]   o_count
);

   logic [DIGITS-1:0] w_is9;
   logic              w_sat;
   logic              w_step;

   assign w_sat  = &w_is9;
   // Saturated counter ignores further increments entirely.
   assign w_step = i_inc & ~w_sat;

   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_digit
         logic [3:0] r_digit;
         logic       w_carry_in;

         // A digit advances when every lower digit is about to wrap.
         if (gi == 0) begin : g_lsd
            assign w_carry_in = w_step;
         end else begin : g_upper
            assign w_carry_in = w_step & (&w_is9[gi-1:0]);
         end

         assign w_is9[gi] = (r_digit == 4'd9);

         always_ff @(posedge clk) begin
            if (rst || i_clr) begin
               r_digit <= 4'd0;
            end else if (w_carry_in) begin
               r_digit <= w_is9[gi] ? 4'd0 : r_digit + 4'd1;
            end
         end

         assign o_count[4*gi +: 4] = r_digit;
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/jump_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : jump_ctrl
//  Description : Game-logic stage ahead of the character sprite block.
//                Converts debounced key levels into one-cycle jump
//                commands, blocks until the character lands, tracks the
//                next platform side (LFSR), a BCD score and game over.
//  Ports       : clk           - 40 MHz system clock
//                rst           - synchronous active-high reset
//                i_module_en   - 0 holds the block in its reset state
//                i_key_left    - left key level
//                i_key_right   - right key level
//                i_landed      - pulse: jump/fall finished
//                o_jump_left   - pulse: correct jump left
//                o_jump_right  - pulse: correct jump right
//                o_jump_fail   - pulse: wrong side, character falls
//                o_next_side   - next platform side, 0 = left, 1 = right
//                o_score       - 4 BCD digits, [3:0] = units
//                o_game_over   - level, set after a fail landing
//  Options     : JUMP_CTRL_TIMEOUT_EN - when defined, an idle counter forces
//                a jump_fail after TIMEOUT_CYCLES cycles without a key.
//  Revision    : 1.0 - initial release
// ============================================================================
module jump_ctrl
   import jump_ctrl_pkg::*;
#(
   parameter logic [15:0] LFSR_SEED      = 16'hACE1,
   parameter int          SCORE_DIGITS   = 4,
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd120_000_000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_module_en,
   input  logic               i_key_left,
   input  logic               i_key_right,
   input  logic               i_landed,
   output logic               o_jump_left,
   output logic               o_jump_right,
   output logic               o_jump_fail,
   output logic               o_next_side,
   output logic [SCORE_W-1:0] o_score,
   output logic               o_game_over
);

   // An all-zero LFSR would lock up, so a zero seed is replaced.
   localparam logic [15:0] c_SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

   logic        w_rst;
   logic        r_key_left_q;
   logic        r_key_right_q;
   logic        w_rise_l;
   logic        w_rise_r;
   logic        w_one_edge;
   logic        w_timeout;
   logic        w_score_inc;
   logic [15:0] w_lfsr_next;

   state_t      r_state;
   logic        r_fail;
   logic [15:0] r_lfsr;

   assign w_rst = rst | ~i_module_en;

   // ------------------------------------------------------------------
   // Key edge detection; history registers track the keys in all states
   // so a key held through a jump never looks like a new press.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (w_rst) begin
         r_key_left_q  <= 1'b0;
         r_key_right_q <= 1'b0;
      end else begin
         r_key_left_q  <= i_key_left;
         r_key_right_q <= i_key_right;
      end
   end

   assign w_rise_l   = i_key_left  & ~r_key_left_q;
   assign w_rise_r   = i_key_right & ~r_key_right_q;
   // Simultaneous presses are ambiguous and dropped.
   assign w_one_edge = w_rise_l ^ w_rise_r;

   assign w_lfsr_next = lfsr_step(r_lfsr);
   assign w_score_inc = (r_state == S_WAIT_LAND) & i_landed & ~r_fail;

`ifdef JUMP_CTRL_TIMEOUT_EN
   // ------------------------------------------------------------------
   // Idle counter: held at zero outside S_WAIT_KEY so every entry into
   // S_WAIT_KEY starts a fresh count.
   // ------------------------------------------------------------------
   logic [31:0] r_idle_cnt;

   always_ff @(posedge clk) begin
      if (w_rst || (r_state != S_WAIT_KEY) || w_one_edge || w_timeout) begin
         r_idle_cnt <= 32'd0;
      end else begin
         r_idle_cnt <= r_idle_cnt + 32'd1;
      end
   end

   assign w_timeout = (r_state == S_WAIT_KEY) && (r_idle_cnt == TIMEOUT_CYCLES - 32'd1);
`else
   logic w_unused_timeout;
   assign w_unused_timeout = ^TIMEOUT_CYCLES;
   assign w_timeout        = 1'b0;
`endif

   // ------------------------------------------------------------------
   // Main FSM with registered command pulses.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (w_rst) begin
         r_state      <= S_WAIT_KEY;
         r_fail       <= 1'b0;
         r_lfsr       <= c_SEED;
         o_next_side  <= c_SEED[0];
         o_jump_left  <= 1'b0;
         o_jump_right <= 1'b0;
         o_jump_fail  <= 1'b0;
         o_game_over  <= 1'b0;
      end else begin
         o_jump_left  <= 1'b0;
         o_jump_right <= 1'b0;
         o_jump_fail  <= 1'b0;

         case (r_state)
            S_WAIT_KEY: begin
               // A real key edge wins over a coincident timeout.
               if (w_one_edge) begin
                  r_state <= S_WAIT_LAND;
                  if (w_rise_l && (o_next_side == SIDE_LEFT)) begin
                     o_jump_left <= 1'b1;
                     r_fail      <= 1'b0;
                  end else if (w_rise_r && (o_next_side == SIDE_RIGHT)) begin
                     o_jump_right <= 1'b1;
                     r_fail       <= 1'b0;
                  end else begin
                     o_jump_fail <= 1'b1;
                     r_fail      <= 1'b1;
                  end
               end else if (w_timeout) begin
                  r_state     <= S_WAIT_LAND;
                  o_jump_fail <= 1'b1;
                  r_fail      <= 1'b1;
               end
            end

            S_WAIT_LAND: begin
               if (i_landed) begin
                  if (r_fail) begin
                     o_game_over <= 1'b1;
                     r_state     <= S_GAME_OVER;
                  end else begin
                     r_lfsr      <= w_lfsr_next;
                     o_next_side <= w_lfsr_next[0];
                     r_state     <= S_WAIT_KEY;
                  end
               end
            end

            S_GAME_OVER: begin
               r_state <= S_GAME_OVER;
            end

            default: begin
               r_state <= S_WAIT_KEY;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Score counter
   // ------------------------------------------------------------------
   jump_ctrl_bcd_counter #(
      .DIGITS (SCORE_DIGITS)
   ) u_score (
      .clk     (clk),
      .rst     (rst),
      .i_clr   (~i_module_en),
      .i_inc   (w_score_inc),
      .o_count (o_score)
   );

endmodule
`default_nettype wire
